// File: rtl/clk_period_meter.sv
// -----------------------------------------------------------------------------
// clk_period_meter
//
// Measures a slow periodic input (divided clock tick, external 1 Hz reference)
// in units of Clk cycles. The input is synchronised, and then rising and
// falling edges are detected. The design reports:
//   - the rising-to-rising period,
//   - the high time within that period,
//   - a tolerance check of the period against an expected count.
// A sticky Timeout flag is raised when no rising edge arrives in time.
//
// Parameters:
//   CNT_W    width of all cycle counters and results
//   TIMEOUT  Clk cycles without a rising edge before a measurement is abandoned
//   TOL      largest |Period - ExpPeriod| for which InTol is set
//
// Ports:
//   Clk        in   system clock
//   Rst        in   synchronous active-high reset
//   SigIn      in   asynchronous slow signal to measure
//   ExpPeriod  in   expected period, sampled on the cycle a Valid is produced
//   Period     out  last measured rising-to-rising period
//   HighTime   out  high time belonging to that period
//   Valid      out  one-cycle pulse when Period/HighTime/InTol update
//   InTol      out  last Period was within TOL of ExpPeriod
//   Timeout    out  sticky: no rising edge seen within TIMEOUT cycles
// -----------------------------------------------------------------------------
module clk_period_meter #(
    parameter int CNT_W   = 26,
    parameter int TIMEOUT = 67108863,
    parameter int TOL     = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             SigIn,
    input  logic [CNT_W-1:0] ExpPeriod,
    output logic [CNT_W-1:0] Period,
    output logic [CNT_W-1:0] HighTime,
    output logic             Valid,
    output logic             InTol,
    output logic             Timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W:0]   TOL_EXT  = (CNT_W + 1)'(TOL);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t           state_reg;
    logic             s1_reg;
    logic             s2_reg;
    logic             s3_reg;
    logic [1:0]       fill_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] high_cnt_reg;
    logic [CNT_W-1:0] high_pend_reg;
    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] high_time_reg;
    logic             valid_reg;
    logic             in_tol_reg;
    logic             timeout_reg;

    logic             rise;
    logic             fall;
    logic             at_limit;
    logic             sync_ready;
    logic [CNT_W:0]   period_ext;
    logic [CNT_W:0]   exp_ext;
    logic [CNT_W:0]   abs_diff;
    logic             in_tol_next;

    always_comb begin
        rise       = s2_reg & ~s3_reg;
        fall       = ~s2_reg & s3_reg;
        at_limit   = (cnt_reg == CNT_LAST);
        // s2 only carries a real SigIn sample once two samples have passed
        // through the synchroniser after reset; before that its 0 is the
        // reset value and would let a signal that is already high at reset
        // release look like a fresh rising edge.
        sync_ready = (fill_reg == 2'd2);
        // One extra bit so the tolerance difference never wraps.
        period_ext = {1'b0, cnt_reg} + 1'b1;
        exp_ext    = {1'b0, ExpPeriod};
        abs_diff   = (period_ext >= exp_ext) ? (period_ext - exp_ext)
                                             : (exp_ext - period_ext);
        in_tol_next = (abs_diff <= TOL_EXT);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg     <= IDLE;
            s1_reg        <= 1'b0;
            s2_reg        <= 1'b0;
            s3_reg        <= 1'b0;
            fill_reg      <= 2'd0;
            cnt_reg       <= '0;
            high_cnt_reg  <= '0;
            high_pend_reg <= '0;
            period_reg    <= '0;
            high_time_reg <= '0;
            valid_reg     <= 1'b0;
            in_tol_reg    <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            s1_reg    <= SigIn;
            s2_reg    <= s1_reg;
            s3_reg    <= s2_reg;
            valid_reg <= 1'b0;
            if (!sync_ready) begin
                fill_reg <= fill_reg + 2'd1;
            end

            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (sync_ready && !s2_reg) begin
                        state_reg <= ARMED;
                    end
                end

                ARMED: begin
                    // The first rise only starts the reference; it produces no result.
                    if (rise) begin
                        cnt_reg      <= '0;
                        high_cnt_reg <= CNT_W'(1);
                        state_reg    <= MEASURE;
                    end else if (at_limit) begin
                        timeout_reg <= 1'b1;
                        cnt_reg     <= '0;
                        state_reg   <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                MEASURE: begin
                    if (rise) begin
                        period_reg    <= period_ext[CNT_W-1:0];
                        high_time_reg <= high_pend_reg;
                        in_tol_reg    <= in_tol_next;
                        valid_reg     <= 1'b1;
                        timeout_reg   <= 1'b0;
                        cnt_reg       <= '0;
                        high_cnt_reg  <= CNT_W'(1);
                    end else begin
                        // High time is latched at the fall so it is ready when
                        // the closing rise arrives.
                        if (fall) begin
                            high_pend_reg <= high_cnt_reg;
                        end
                        if (at_limit) begin
                            timeout_reg <= 1'b1;
                            cnt_reg     <= '0;
                            state_reg   <= IDLE;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                            if (s2_reg) begin
                                high_cnt_reg <= high_cnt_reg + 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign Period   = period_reg;
    assign HighTime = high_time_reg;
    assign Valid    = valid_reg;
    assign InTol    = in_tol_reg;
    assign Timeout  = timeout_reg;

endmodule
